pong_input_cond: RTL and testbench
==================================

// Module: pong_input_cond
// PURPOSE
//  Upstream stage of the pong game controller: conditions raw board inputs into clean per-frame controls.
//  Runs on the frame clock.
//  Per input: synchronizes, debounces, and resolves up/down conflicts.
//  Drives the controller's btn_i (held levels) and start_i (single-frame pulse).
// PARAMETERS
//  DEBOUNCE_FRAMES  3    consecutive frames a changed input must hold before it is accepted (>=1)
//  HOLDOFF_FRAMES   120  frames start is ignored after a start pulse (only with START_HOLDOFF_EN, >=1)
// PORTS
//  clk_frame_i   in   1  frame-rate clock, sole clock
//  rst_i         in   1  asynchronous, active-high reset
//  btn_raw_i     in   2  raw paddle buttons, asynchronous; [0]=down (pos_y++), [1]=up (pos_y--)
//  start_raw_i   in   1  raw start button, asynchronous
//  btn_o         out  2  conditioned paddle levels, to game controller btn_i
//  start_o       out  1  one-cycle start pulse, to game controller start_i
//  conflict_o    out  1  high while both debounced paddle buttons are pressed
// BEHAVIOUR
//  Reset (async assert, sync-released by the flops): all sync flops, debounced states, counters,
//  btn_o, start_o and conflict_o go to 0.
//  Synchronizer: 2 flops per raw input; the sampled value s is taken from the second flop.
//  Debounce (independent per input; 3 instances):
//  - State d and counter cnt, width $clog2(DEBOUNCE_FRAMES+1).
//  - s==d: cnt<=0.
//  - s!=d and cnt==DEBOUNCE_FRAMES-1: d<=s, cnt<=0.
//  - s!=d otherwise: cnt<=cnt+1.
//  - A glitch shorter than DEBOUNCE_FRAMES frames never changes d; cnt restarts from 0 on each reversal.
//  - Latency from a raw edge to a d change: 2 (sync) + DEBOUNCE_FRAMES cycles.
//  Paddle outputs are registered, 1 cycle after d:
//  - d_btn==2'b11: btn_o<=2'b00 and conflict_o<=1 (no paddle motion on conflict).
//  - Otherwise: btn_o<=d_btn and conflict_o<=0.
//  Start: start_o<=1 for exactly one cycle on a 0->1 transition of d_start; it is 0 otherwise.
//  - Holding start never re-pulses; a new press is needed after d_start returns to 0.
//  Reset mid-operation: any partially counted debounce is discarded; pending start edges are not
//  remembered. After release, inputs already held high count as fresh edges once debounced.
// CONFIGURATION
//  START_HOLDOFF_EN defined:
//  - Issuing start_o loads hold_cnt<=HOLDOFF_FRAMES.
//  - While hold_cnt!=0: it decrements each cycle and d_start rising edges are dropped, not queued.
//  - Drops d_start rises that coincide with or follow start_o until hold_cnt==0.
//  - hold_cnt resets to 0.
//  START_HOLDOFF_EN undefined: no hold_cnt logic; every d_start rising edge pulses start_o.
// STRUCTURE
//  pong_pkg (shared):
//  - localparams BTN_DOWN=0, BTN_UP=1.
//  - Default DEBOUNCE_FRAMES.
//  - typedef struct packed {logic [1:0] btn; logic start;} ctrl_in_t.
//  Sub-module btn_debounce #(DEBOUNCE_FRAMES): one input, contains sync + counter, outputs d.
//  Top: 3x btn_debounce, conflict resolver, start edge detector, optional holdoff counter.
// TESTING
//  1. Assert rst_i mid-cycle with inputs high -> all outputs 0 immediately.
//     After release with inputs held high, outputs go high only after 2+3 frames.
//  2. btn_raw_i[0] high for 2 frames, then low (DEBOUNCE_FRAMES=3) -> btn_o stays 2'b00.
//     Held 3+ frames -> btn_o==2'b01 at cycle 6 after the raw edge.
//  3. btn_raw_i=2'b11 held -> btn_o==2'b00 and conflict_o==1.
//     Release bit 1 -> btn_o==2'b01 and conflict_o==0 six frames later.
//  4. start_raw_i held 50 frames -> exactly one start_o pulse, 6 cycles after the edge.
//     Release, then press again -> a second pulse.
//  5. START_HOLDOFF_EN, HOLDOFF_FRAMES=10: second clean press debounced 5 frames after the first pulse
//     -> no pulse. Press debounced 12 frames after the first pulse -> pulse.
//     Without the macro, both presses pulse.
//  6. Raw start toggling every frame for 20 frames -> no start_o and d_start unchanged.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared paddle bit indices, default debounce length and raw-control bundle type.
package pong_pkg;
    localparam int BTN_DOWN = 0;
    localparam int BTN_UP = 1;
    localparam int DEBOUNCE_FRAMES_DEF = 3;
    typedef struct packed {
        logic [1:0] btn;
        logic       start;
    } ctrl_in_t;
endpackage

// File: rtl/pong_input_cond_if.sv
// pong_input_cond_if: raw board inputs in, conditioned per-frame controls out.
interface pong_input_cond_if;
    logic [1:0] btn_raw_i;
    logic       start_raw_i;
    logic [1:0] btn_o;
    logic       start_o;
    logic       conflict_o;
    modport master (output btn_raw_i, start_raw_i, input btn_o, start_o, conflict_o);
    modport slave (input btn_raw_i, start_raw_i, output btn_o, start_o, conflict_o);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus consecutive-frame debounce of one raw input.
module btn_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic d
);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            d <= 1'b0;
            cnt <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == d) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_FRAMES - 1)) begin
                d <= sync[1];
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pong_input_cond.sv
// pong_input_cond: debounced paddle levels with conflict masking and a one-frame start pulse.
// Optional START_HOLDOFF_EN ignores new start presses for HOLDOFF_FRAMES after each pulse.
module pong_input_cond
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
`ifdef START_HOLDOFF_EN
    , parameter int HOLDOFF_FRAMES = 120
`endif
) (
    input  logic clk_frame_i,
    input  logic rst_i,
    pong_input_cond_if.slave io
);
    ctrl_in_t raw, d;
    logic start_q, conflict, rise, fire;
    assign raw = '{btn: io.btn_raw_i, start: io.start_raw_i};
    for (genvar i = 0; i < 3; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db (
            .clk(clk_frame_i), .rst(rst_i), .raw(raw[i]), .d(d[i])
        );
    end
    assign conflict = d.btn[BTN_UP] & d.btn[BTN_DOWN];
    assign rise = d.start & ~start_q;
`ifdef START_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
    logic [HW-1:0] hold_cnt;
    assign fire = rise && hold_cnt == '0;
    always_ff @(posedge clk_frame_i or posedge rst_i) begin
        if (rst_i) hold_cnt <= '0;
        else if (fire) hold_cnt <= HW'(HOLDOFF_FRAMES);
        else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
`else
    assign fire = rise;
`endif
    always_ff @(posedge clk_frame_i or posedge rst_i) begin
        if (rst_i) begin
            io.btn_o <= '0;
            io.conflict_o <= 1'b0;
            io.start_o <= 1'b0;
            start_q <= 1'b0;
        end else begin
            io.btn_o <= conflict ? 2'b00 : d.btn;
            io.conflict_o <= conflict;
            io.start_o <= fire;
            start_q <= d.start;
        end
    end
endmodule

// File: tb/tb_pong_input_cond.sv
// tb_pong_input_cond: window-based debounce model checked every frame plus directed literal checks.
module tb_pong_input_cond;
    localparam int N = 3;
    localparam int H = 10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int fails = 0;
    int pulses = 0;
    pong_input_cond_if io ();
`ifdef START_HOLDOFF_EN
    pong_input_cond #(.DEBOUNCE_FRAMES(N), .HOLDOFF_FRAMES(H)) dut (.clk_frame_i(clk), .rst_i(rst), .io(io.slave));
`else
    pong_input_cond #(.DEBOUNCE_FRAMES(N)) dut (.clk_frame_i(clk), .rst_i(rst), .io(io.slave));
`endif
    always #5 clk = ~clk;

    // Model: an input's accepted level flips once its last N sampled frames all disagree with it.
    logic [2:0] p1, p2, s, md, md_prev;
    logic [2:0] win [N];
    logic [1:0] e_btn;
    logic e_start, e_conf, rise, flip;
    int cyc, last_pulse;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 = '0; p2 = '0; md = '0; md_prev = '0;
            for (int j = 0; j < N; j++) win[j] = '0;
            e_btn = '0; e_start = 1'b0; e_conf = 1'b0;
            cyc = 0; last_pulse = -1000;
        end else begin
            cyc++;
            e_conf = md[2:1] == 2'b11;
            e_btn = e_conf ? 2'b00 : md[2:1];
            rise = md[0] && !md_prev[0];
`ifdef START_HOLDOFF_EN
            e_start = rise && (cyc - last_pulse > H);
`else
            e_start = rise;
`endif
            if (e_start) last_pulse = cyc;
            md_prev = md;
            s = p2;
            for (int j = 0; j < N - 1; j++) win[j] = win[j + 1];
            win[N - 1] = s;
            for (int b = 0; b < 3; b++) begin
                flip = 1'b1;
                for (int j = 0; j < N; j++) if (win[j][b] == md[b]) flip = 1'b0;
                if (flip) md[b] = ~md[b];
            end
            p2 = p1;
            p1 = {io.btn_raw_i, io.start_raw_i};
        end
    end

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_btn", {2'b00, io.btn_o}, {2'b00, e_btn});
            chk("model_start", {3'b000, io.start_o}, {3'b000, e_start});
            chk("model_conflict", {3'b000, io.conflict_o}, {3'b000, e_conf});
            if (io.start_o) pulses++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        io.btn_raw_i = 2'b00;
        io.start_raw_i = 1'b0;
        step(2);
        rst = 1'b0;
        step(3);
        chk("reset_btn", {2'b00, io.btn_o}, 4'h0);
        // 1: reset mid-operation with inputs held high
        io.btn_raw_i = 2'b01;
        io.start_raw_i = 1'b1;
        step(10);
        chk("pre_rst_btn", {2'b00, io.btn_o}, 4'h1);
        rst = 1'b1;
        #1;
        chk("rst_btn", {2'b00, io.btn_o}, 4'h0);
        chk("rst_start", {3'b000, io.start_o}, 4'h0);
        chk("rst_conf", {3'b000, io.conflict_o}, 4'h0);
        step(1);
        rst = 1'b0;
        step(5);
        chk("rel_btn_early", {2'b00, io.btn_o}, 4'h0);
        chk("rel_start_early", {3'b000, io.start_o}, 4'h0);
        step(1);
        chk("rel_btn", {2'b00, io.btn_o}, 4'h1);
        chk("rel_start", {3'b000, io.start_o}, 4'h1);
        step(1);
        chk("rel_start_once", {3'b000, io.start_o}, 4'h0);
        io.btn_raw_i = 2'b00;
        io.start_raw_i = 1'b0;
        step(10);
        // 2: short glitch rejected, long press accepted at cycle 6
        io.btn_raw_i = 2'b01;
        step(2);
        io.btn_raw_i = 2'b00;
        step(10);
        chk("glitch_btn", {2'b00, io.btn_o}, 4'h0);
        io.btn_raw_i = 2'b01;
        step(5);
        chk("press_btn_c5", {2'b00, io.btn_o}, 4'h0);
        step(1);
        chk("press_btn_c6", {2'b00, io.btn_o}, 4'h1);
        // 3: conflict
        io.btn_raw_i = 2'b11;
        step(10);
        chk("conf_btn", {2'b00, io.btn_o}, 4'h0);
        chk("conf_flag", {3'b000, io.conflict_o}, 4'h1);
        io.btn_raw_i = 2'b01;
        step(5);
        chk("conf_hold", {3'b000, io.conflict_o}, 4'h1);
        step(1);
        chk("unconf_btn", {2'b00, io.btn_o}, 4'h1);
        chk("unconf_flag", {3'b000, io.conflict_o}, 4'h0);
        io.btn_raw_i = 2'b00;
        step(10);
        // 4: long hold pulses once, re-press pulses again
        pulses = 0;
        io.start_raw_i = 1'b1;
        step(5);
        chk("start_c5", {3'b000, io.start_o}, 4'h0);
        step(1);
        chk("start_c6", {3'b000, io.start_o}, 4'h1);
        step(44);
        chk("hold_pulses", 4'(pulses), 4'h1);
        io.start_raw_i = 1'b0;
        step(10);
        io.start_raw_i = 1'b1;
        step(10);
        chk("repress_pulses", 4'(pulses), 4'h2);
        io.start_raw_i = 1'b0;
        step(20);
        // 5: presses debounced 5 and 12 frames after the first pulse
        pulses = 0;
        io.start_raw_i = 1'b1;
        step(3);
        io.start_raw_i = 1'b0;
        step(3);
        io.start_raw_i = 1'b1;
        step(3);
        io.start_raw_i = 1'b0;
        step(4);
        io.start_raw_i = 1'b1;
        step(3);
        io.start_raw_i = 1'b0;
        step(15);
`ifdef START_HOLDOFF_EN
        chk("holdoff_pulses", 4'(pulses), 4'h2);
`else
        chk("holdoff_pulses", 4'(pulses), 4'h3);
`endif
        // 6: start chatter never accepted
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            io.start_raw_i = ~io.start_raw_i;
            step(1);
        end
        io.start_raw_i = 1'b0;
        step(10);
        chk("chatter_pulses", 4'(pulses), 4'h0);
        chk("chatter_model_d", {3'b000, md[0]}, 4'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
